// File: rtl/pid_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pid_multi
//  Purpose  : Time-multiplexed multi-channel PID controller. One accepted
//             start_calc updates every channel in turn (P, I, D, SUM steps per
//             channel) on sign-magnitude data, then publishes all outputs at
//             once with a single-cycle done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          clock, all state updates on posedge
//    nrst       in   1          asynchronous active-low reset
//    en         in   1          clock enable, low freezes all state
//    start_calc in   1          request one update of all channels
//    error      in   NCH*WIDTH  per-channel error, ch c at [c*WIDTH +: WIDTH]
//    Kp/Ki/Kd   in   NCH*WIDTH  per-channel gains, same packing
//    delta_t    in   WIDTH      shared timestep, unsigned magnitude
//    PID_out    out  NCH*WIDTH  per-channel result, same packing
//    done       out  1          one-cycle pulse when PID_out is updated
//    busy       out  1          calculation in progress
//  Configuration
//    PID_ANTIWINDUP_EN  when defined, each integrator is clamped to
//                       magnitude I_LIMIT after every update.
// ============================================================================
module pid_multi #(
    parameter int WIDTH   = 32,
    parameter int NCH     = 3,
    parameter int I_LIMIT = 2**(WIDTH-2)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   start_calc,
    input  logic [NCH*WIDTH-1:0]   error,
    input  logic [NCH*WIDTH-1:0]   Kp,
    input  logic [NCH*WIDTH-1:0]   Ki,
    input  logic [NCH*WIDTH-1:0]   Kd,
    input  logic [WIDTH-1:0]       delta_t,
    output logic [NCH*WIDTH-1:0]   PID_out,
    output logic                   done,
    output logic                   busy
);

    localparam int MAGW = WIDTH - 1;
    // Wide enough for Ki*e*delta_t plus the integrator without overflow.
    localparam int XW   = 3*WIDTH + 2;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [XW-1:0] c_SMAX = {{(XW-MAGW){1'b0}}, {MAGW{1'b1}}};

`ifdef PID_ANTIWINDUP_EN
    localparam bit c_ANTIWINDUP = 1'b1;
`else
    localparam bit c_ANTIWINDUP = 1'b0;
`endif

    localparam logic signed [XW-1:0] c_ILIM_RAW = XW'(I_LIMIT);
    localparam logic signed [XW-1:0] c_ILIM =
        (c_ANTIWINDUP && (c_ILIM_RAW < c_SMAX)) ? c_ILIM_RAW : c_SMAX;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P    = 3'd1,
        S_I    = 3'd2,
        S_D    = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Sign-magnitude to wide two's complement; -0 naturally becomes 0.
    function automatic logic signed [XW-1:0] sm2x(input logic [WIDTH-1:0] v);
        logic signed [XW-1:0] m;
        m = $signed({{(XW-MAGW){1'b0}}, v[MAGW-1:0]});
        return v[WIDTH-1] ? -m : m;
    endfunction

    function automatic logic signed [XW-1:0] s2x(input logic signed [WIDTH-1:0] v);
        return $signed({{(XW-WIDTH){v[WIDTH-1]}}, v});
    endfunction

    // Symmetric clamp to +/-lim, result fits a WIDTH-bit two's complement.
    function automatic logic signed [WIDTH-1:0] clampx(input logic signed [XW-1:0] v,
                                                       input logic signed [XW-1:0] lim);
        logic signed [XW-1:0] r;
        if (v > lim)       r = lim;
        else if (v < -lim) r = -lim;
        else               r = v;
        return WIDTH'(r);
    endfunction

    // Two's complement back to sign-magnitude; zero always gets sign 0.
    function automatic logic [WIDTH-1:0] x2sm(input logic signed [WIDTH-1:0] v);
        if (v < 0) return {1'b1, MAGW'(-v)};
        else       return {1'b0, MAGW'(v)};
    endfunction

    state_t                     state_q, state_d;
    logic [CHW-1:0]             ch_q;
    logic [NCH*WIDTH-1:0]       err_q, kp_q, ki_q, kd_q;
    logic [WIDTH-1:0]           dt_q;
    logic signed [WIDTH-1:0]    p_q, d_q;
    logic signed [WIDTH-1:0]    integ_q [NCH];
    logic signed [WIDTH-1:0]    eprev_q [NCH];
    logic [NCH*WIDTH-1:0]       acc_q;
    logic [NCH*WIDTH-1:0]       pid_out_q;
    logic                       done_q, busy_q;

    logic                       w_accept;
    logic                       w_last_ch;
    logic signed [XW-1:0]       w_e_x;
    logic signed [XW-1:0]       w_p_x, w_i_x, w_d_x, w_sum_x;

    assign w_accept  = (state_q == S_IDLE) && start_calc;
    assign w_last_ch = (32'(ch_q) == NCH - 1);

    // Current-channel arithmetic at full precision.
    always_comb begin
        w_e_x   = sm2x(err_q[ch_q*WIDTH +: WIDTH]);
        w_p_x   = sm2x(kp_q[ch_q*WIDTH +: WIDTH]) * w_e_x;
        w_i_x   = s2x(integ_q[ch_q])
                + sm2x(ki_q[ch_q*WIDTH +: WIDTH]) * w_e_x
                  * $signed({{(XW-WIDTH){1'b0}}, dt_q});
        w_d_x   = sm2x(kd_q[ch_q*WIDTH +: WIDTH]) * (w_e_x - s2x(eprev_q[ch_q]));
        w_sum_x = s2x(p_q) + s2x(integ_q[ch_q]) + s2x(d_q);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)   state_q <= S_IDLE;
        else if (en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_calc) state_d = S_P;
            S_P:     state_d = S_I;
            S_I:     state_d = S_D;
            S_D:     state_d = S_SUM;
            S_SUM:   state_d = w_last_ch ? S_DONE : S_P;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ch_q      <= '0;
            err_q     <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            dt_q      <= '0;
            p_q       <= '0;
            d_q       <= '0;
            acc_q     <= '0;
            pid_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                integ_q[c] <= '0;
                eprev_q[c] <= '0;
            end
        end else if (en) begin
            // done only lives for the single enabled cycle after DONE.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        err_q  <= error;
                        kp_q   <= Kp;
                        ki_q   <= Ki;
                        kd_q   <= Kd;
                        dt_q   <= delta_t;
                        ch_q   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_P:   p_q           <= clampx(w_p_x, c_SMAX);
                S_I:   integ_q[ch_q] <= clampx(w_i_x, c_ILIM);
                S_D:   d_q           <= clampx(w_d_x, c_SMAX);
                S_SUM: begin
                    acc_q[ch_q*WIDTH +: WIDTH] <= x2sm(clampx(w_sum_x, c_SMAX));
                    eprev_q[ch_q]              <= clampx(w_e_x, c_SMAX);
                    if (!w_last_ch) ch_q <= ch_q + 1'b1;
                end
                S_DONE: begin
                    pid_out_q <= acc_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign PID_out = pid_out_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_multi
//  Purpose  : Directed self-checking bench for pid_multi (WIDTH=32, NCH=3,
//             I_LIMIT=1000). Expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_multi;

    localparam int W = 32;
    localparam int N = 3;

`ifdef PID_ANTIWINDUP_EN
    localparam bit AW = 1'b1;
`else
    localparam bit AW = 1'b0;
`endif

    // Basic vector (Kp=1, Ki=1, Kd=3, dt=1, e0=5000) after reset.
    // Run 1: 5000 + I + 15000, run 2: 5000 + I + 0; I clamps to 1000 under AW.
    localparam logic [W-1:0] E_RUN1 = AW ? 32'd21000 : 32'd25000;
    localparam logic [W-1:0] E_RUN2 = AW ? 32'd6000  : 32'd15000;

    logic             clk = 1'b0;
    logic             nrst, en, start_calc;
    logic [N*W-1:0]   error, Kp, Ki, Kd, PID_out;
    logic [W-1:0]     delta_t;
    logic             done, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pid_multi #(.WIDTH(W), .NCH(N), .I_LIMIT(1000)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .start_calc (start_calc),
        .error      (error),
        .Kp         (Kp),
        .Ki         (Ki),
        .Kd         (Kd),
        .delta_t    (delta_t),
        .PID_out    (PID_out),
        .done       (done),
        .busy       (busy)
    );

    task automatic set_gains(input logic [W-1:0] kp, ki, kd, dt);
        for (int c = 0; c < N; c++) begin
            Kp[c*W +: W] = kp;
            Ki[c*W +: W] = ki;
            Kd[c*W +: W] = kd;
        end
        delta_t = dt;
    endtask

    task automatic set_err(input logic [W-1:0] e0, e1, e2);
        error = {e2, e1, e0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
    endtask

    // One start pulse; lat = edges after the accepting edge until done seen.
    task automatic run(output int lat);
        @(negedge clk);
        start_calc = 1'b1;
        @(posedge clk);
        #1 start_calc = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat < 0) begin
            n_bad++;
            $display("FAIL run_timeout: done never seen within 40 cycles, required at 13");
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b1; start_calc = 1'b0;
        set_gains(32'd7, 32'd7, 32'd7, 32'd1);
        set_err(32'd9, 32'd9, 32'd9);
        #12;
        n_cmp++; if (PID_out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", PID_out); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        nrst = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        set_gains(32'd1, 32'd1, 32'd3, 32'd1);
        set_err(32'd5000, 32'd0, 32'd0);
        run(lat);
        n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL basic_latency: got %0d want 13", lat); end
        n_cmp++; if (PID_out[0 +: W] !== E_RUN1) begin n_bad++; $display("FAIL basic_run1_ch0: got %h want %h", PID_out[0 +: W], E_RUN1); end
        n_cmp++; if (PID_out[W +: W] !== 32'd0) begin n_bad++; $display("FAIL basic_run1_ch1: got %h want 0", PID_out[W +: W]); end
        run(lat);
        n_cmp++; if (PID_out[0 +: W] !== E_RUN2) begin n_bad++; $display("FAIL basic_run2_ch0: got %h want %h", PID_out[0 +: W], E_RUN2); end
    endtask

    task automatic test_negative();
        int lat;
        do_reset();
        set_gains(32'd1, 32'd1, 32'd3, 32'd1);
        set_err(32'd5000, 32'h800000C8, 32'd0);
        run(lat);
        n_cmp++; if (PID_out[0 +: W] !== E_RUN1) begin n_bad++; $display("FAIL neg_ch0: got %h want %h", PID_out[0 +: W], E_RUN1); end
        n_cmp++; if (PID_out[W +: W] !== 32'h800003E8) begin n_bad++; $display("FAIL neg_ch1: got %h want 800003e8", PID_out[W +: W]); end
        n_cmp++; if (PID_out[2*W +: W] !== 32'd0) begin n_bad++; $display("FAIL neg_ch2: got %h want 0", PID_out[2*W +: W]); end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        set_gains(32'h10000, 32'd0, 32'd0, 32'd1);
        set_err(32'h10000, 32'h10000, 32'h10000);
        run(lat);
        n_cmp++; if (PID_out[0 +: W] !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL sat_pos_ch0: got %h want 7fffffff", PID_out[0 +: W]); end
        n_cmp++; if (PID_out[2*W +: W] !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL sat_pos_ch2: got %h want 7fffffff", PID_out[2*W +: W]); end
        set_err(32'h80010000, 32'h80010000, 32'h80010000);
        run(lat);
        n_cmp++; if (PID_out[0 +: W] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL sat_neg_ch0: got %h want ffffffff", PID_out[0 +: W]); end
        // Negative zero input must yield +0.
        do_reset();
        set_gains(32'd1, 32'd0, 32'd0, 32'd1);
        set_err(32'h80000000, 32'h80000000, 32'h80000000);
        run(lat);
        n_cmp++; if (PID_out[W +: W] !== 32'd0) begin n_bad++; $display("FAIL neg_zero_ch1: got %h want 0", PID_out[W +: W]); end
    endtask

    task automatic test_antiwindup();
        int lat;
        logic [W-1:0] exp_v [3];
        exp_v[0] = 32'd600;
        exp_v[1] = AW ? 32'd1000 : 32'd1200;
        exp_v[2] = AW ? 32'd1000 : 32'd1800;
        do_reset();
        set_gains(32'd0, 32'd1, 32'd0, 32'd1);
        set_err(32'd600, 32'd600, 32'd600);
        for (int r = 0; r < 3; r++) begin
            run(lat);
            n_cmp++;
            if (PID_out[W +: W] !== exp_v[r]) begin
                n_bad++;
                $display("FAIL integ_run%0d_ch1: got %0d want %0d", r, PID_out[W +: W], exp_v[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone, first;
        do_reset();
        set_gains(32'd1, 32'd1, 32'd3, 32'd1);
        set_err(32'd5000, 32'd0, 32'd0);
        @(negedge clk);
        start_calc = 1'b1;
        @(posedge clk);
        #1 start_calc = 1'b0;
        ndone = 0;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) start_calc = 1'b1;
            if (i == 6) start_calc = 1'b0;
            @(posedge clk);
            #1;
            if (i == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hs_busy_rise: got %b want 1", busy); end
            end
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hs_busy_fall: got %b want 0", busy); end
                end
            end
        end
        n_cmp++; if (first !== 13) begin n_bad++; $display("FAIL hs_latency: got %0d want 13", first); end
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL hs_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_enable();
        int first;
        do_reset();
        set_gains(32'd1, 32'd1, 32'd3, 32'd1);
        set_err(32'd5000, 32'd0, 32'd0);
        @(negedge clk);
        start_calc = 1'b1;
        @(posedge clk);
        #1 start_calc = 1'b0;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            en = !(i >= 4 && i <= 13);
            @(posedge clk);
            #1;
            if (done) begin
                first = i;
                break;
            end
        end
        en = 1'b1;
        n_cmp++; if (first !== 23) begin n_bad++; $display("FAIL en_latency: got %0d want 23", first); end
        // done must persist while the clock enable is low.
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL en_done_hold: got %b want 1", done); end
        n_cmp++; if (PID_out[0 +: W] !== E_RUN1) begin n_bad++; $display("FAIL en_out: got %h want %h", PID_out[0 +: W], E_RUN1); end
        en = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL en_done_drop: got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        int lat, ndone;
        do_reset();
        set_gains(32'd1, 32'd1, 32'd3, 32'd1);
        set_err(32'd5000, 32'd0, 32'd0);
        run(lat);
        @(negedge clk);
        start_calc = 1'b1;
        @(posedge clk);
        #1 start_calc = 1'b0;
        repeat (5) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        n_cmp++; if (PID_out !== '0) begin n_bad++; $display("FAIL mid_rst_out: got %h want 0", PID_out); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        nrst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL mid_rst_no_done: got %0d want 0", ndone); end
        run(lat);
        n_cmp++; if (PID_out[0 +: W] !== E_RUN1) begin n_bad++; $display("FAIL mid_rst_rerun: got %h want %h", PID_out[0 +: W], E_RUN1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_antiwindup();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_multi.md
PID_MULTI -- requirements
Module: pid_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning word width of every sign-magnitude value (bit WIDTH-1 = sign, rest = magnitude).
REQ-002 SHALL have parameter NCH, default 3, meaning number of independent PID channels.
REQ-003 SHALL have parameter I_LIMIT, default 2**(WIDTH-2), meaning the integrator magnitude clamp (used only under REQ-026).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  clock enable; low freezes all state.
REQ-007 start_calc  input  1  request one update of all channels.
REQ-008 error  input  NCH*WIDTH  per-channel error; channel c in bits [c*WIDTH +: WIDTH].
REQ-009 Kp, Ki, Kd  input  NCH*WIDTH each  per-channel gains, sign-magnitude, same packing.
REQ-010 delta_t  input  WIDTH  shared timestep, unsigned magnitude.
REQ-011 PID_out  output  NCH*WIDTH  per-channel result, same packing.
REQ-012 done  output  1  one-cycle pulse when PID_out has been updated.
REQ-013 busy  output  1  high while a calculation is in progress.

Function
REQ-014 When en=1, busy=0 and start_calc=1, the block SHALL latch error, Kp, Ki, Kd and delta_t on that edge and set busy=1.
REQ-015 The block SHALL ignore start_calc while busy=1.
REQ-016 The FSM SHALL have states IDLE, P, I, D, SUM, DONE:
- IDLE->P on an accepted start.
- P->I->D->SUM, one cycle each per channel, channel 0 first.
- SUM->P for the next channel; SUM->DONE after channel NCH-1.
- DONE->IDLE unconditionally.
REQ-017 Per channel c, with e = latched error:
- P = Kp*e.
- I_c = I_c + Ki*e*delta_t.
- D = Kd*(e - e_prev_c).
- out_c = P + I_c + D.
- e_prev_c is updated to e in SUM.
REQ-018 All intermediate products and sums SHALL be computed at full precision, then saturated to magnitude 2**(WIDTH-1)-1 with the sign preserved.
REQ-019 A result of magnitude 0 SHALL have sign bit 0; an input of -0 SHALL be treated as +0.
REQ-020 In DONE, PID_out SHALL be updated for all channels simultaneously and done SHALL be high for exactly that one cycle.
- done is high in the cycle following edge k+4*NCH+1, where k is the accepting edge (13 cycles for NCH=3).
- busy falls in that same cycle.
REQ-021 PID_out SHALL hold its value between done pulses.
REQ-022 With en=0, the FSM, counters, accumulators and outputs SHALL hold their values; a done pulse already asserted SHALL stay high until the next enabled edge.

Reset
REQ-023 On nrst=0, the block SHALL immediately clear PID_out, all I_c, all e_prev_c, done and busy to 0 and force the FSM to IDLE, including mid-calculation.
REQ-024 After reset, the first calculation SHALL use e_prev=0, so D = Kd*e.

Configuration
REQ-025 The macro PID_ANTIWINDUP_EN SHALL select the integrator clamping mode.
REQ-026 With PID_ANTIWINDUP_EN defined, each I_c SHALL be clamped to magnitude I_LIMIT after every update, sign preserved.
REQ-027 Without PID_ANTIWINDUP_EN, I_c SHALL saturate only at 2**(WIDTH-1)-1 and I_LIMIT SHALL be unused.

Verification
REQ-028 Basic update, WIDTH=32, NCH=3, all Kp=1, Ki=1, Kd=3, delta_t=1, error ch0=5000 -> run 1: ch0 PID_out=25000; run 2 with the same error: ch0 PID_out=15000.
REQ-029 Negative error, same gains, ch1 error=-200 (0x800000C8) -> ch1 PID_out=0x800003E8 (-1000), with ch0 and ch2 unaffected.
REQ-030 Saturation: Kp=0x10000, Ki=0, Kd=0, error=0x10000 -> PID_out=0x7FFFFFFF; with error=-0x10000 -> PID_out=0xFFFFFFFF.
REQ-031 Anti-windup with PID_ANTIWINDUP_EN, I_LIMIT=1000, Kp=0, Kd=0, Ki=1, delta_t=1, error=600 for three runs -> PID_out 600, 1000, 1000; without the macro -> 600, 1200, 1800.
REQ-032 Handshake, NCH=3:
- done is high exactly 13 cycles after start.
- A second start_calc pulse during busy produces no additional done.
REQ-033 Reset mid-calculation: nrst pulsed low while busy=1 -> PID_out=0, busy=0, no done; the next run reproduces the post-reset values of REQ-028.
